branch_update_queue: RTL



---
 rtl/branch_update_queue_if.sv | 25 ++
 rtl/branch_update_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/branch_update_queue_if.sv
// Commit-side handshake and predictor-update bus of the branch update queue.
//   commit_valid/PC/taken/pred : RoB -> queue, committed conditional branch
//   commit_ready               : queue -> RoB, accept this cycle
//   update_en/PC/result        : queue -> predictor, registered update strobe
// master = RoB / predictor side, slave = the queue itself.
interface branch_update_queue_if;
    logic        commit_valid;
    logic [31:0] commit_PC;
    logic        commit_taken;
    logic        commit_pred;
    logic        commit_ready;
    logic        update_en;
    logic [31:0] update_PC;
    logic        update_result;

    modport master (
        output commit_valid, commit_PC, commit_taken, commit_pred,
        input  commit_ready, update_en, update_PC, update_result
    );

    modport slave (
        input  commit_valid, commit_PC, commit_taken, commit_pred,
        output commit_ready, update_en, update_PC, update_result
    );
endinterface

// File: rtl/branch_update_queue.sv
// Branch update queue: buffers committed conditional-branch outcomes from the
// RoB in a circular FIFO and replays them, one per cycle, onto the branch
// predictor's update port. Also keeps saturating branch/mispredict counters.
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-high reset (wins over rdy_in)
//   rdy_in           global ready; low freezes all state
//   bus              commit handshake in, predictor update strobe out
//   occupancy        entries currently stored
//   branch_count     accepted committed branches (saturating)
//   mispredict_count accepted branches with taken != pred (saturating)
module branch_update_queue #(
    parameter int DEPTH_WIDTH = 3,
    parameter int DEPTH       = 1 << DEPTH_WIDTH,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    branch_update_queue_if.slave    bus,
    output logic [DEPTH_WIDTH:0]    occupancy,
    output logic [CNT_WIDTH-1:0]    branch_count,
    output logic [CNT_WIDTH-1:0]    mispredict_count
);
    localparam int OCC_W = DEPTH_WIDTH + 1;
    localparam logic [OCC_W-1:0]       OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]       OCC_ONE  = OCC_W'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;

    // Entry layout: {PC[31:0], taken}
    logic [32:0]            mem_q [DEPTH];

    logic [DEPTH_WIDTH-1:0] head_q, head_d;
    logic [DEPTH_WIDTH-1:0] tail_q, tail_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   upd_en_q, upd_en_d;
    logic [31:0]            upd_pc_q, upd_pc_d;
    logic                   upd_res_q, upd_res_d;
    logic [CNT_WIDTH-1:0]   bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0]   mcnt_q, mcnt_d;

    logic commit_ready;
    logic push;
    logic pop;

    // Ready ignores a same-cycle pop: a full queue refuses input outright.
    assign commit_ready = rdy_in && (occ_q != OCC_FULL);
    assign push         = rdy_in && bus.commit_valid && commit_ready;
    // Pop is decided on the pre-edge occupancy, so an entry pushed on this
    // edge is never strobed on the same edge.
    assign pop          = rdy_in && (occ_q != '0);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        upd_en_d  = upd_en_q;
        upd_pc_d  = upd_pc_q;
        upd_res_d = upd_res_q;
        bcnt_d    = bcnt_q;
        mcnt_d    = mcnt_q;

        if (push) begin
            tail_d = tail_q + PTR_ONE;
            if (bcnt_q != CNT_MAX) begin
                bcnt_d = bcnt_q + CNT_ONE;
            end
            if ((bus.commit_taken != bus.commit_pred) && (mcnt_q != CNT_MAX)) begin
                mcnt_d = mcnt_q + CNT_ONE;
            end
        end

        if (pop) begin
            head_d    = head_q + PTR_ONE;
            upd_en_d  = 1'b1;
            upd_pc_d  = mem_q[head_q][32:1];
            upd_res_d = mem_q[head_q][0];
        end else if (rdy_in) begin
            // Data fields hold their last value; only the strobe drops.
            upd_en_d  = 1'b0;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            upd_en_q  <= 1'b0;
            upd_pc_q  <= '0;
            upd_res_q <= 1'b0;
            bcnt_q    <= '0;
            mcnt_q    <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            upd_en_q  <= upd_en_d;
            upd_pc_q  <= upd_pc_d;
            upd_res_q <= upd_res_d;
            bcnt_q    <= bcnt_d;
            mcnt_q    <= mcnt_d;
        end
    end

    // Storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk_in) begin
        if (push && !rst_in) begin
            mem_q[tail_q] <= {bus.commit_PC, bus.commit_taken};
        end
    end

    assign bus.commit_ready  = commit_ready;
    assign bus.update_en     = upd_en_q;
    assign bus.update_PC     = upd_pc_q;
    assign bus.update_result = upd_res_q;
    assign occupancy         = occ_q;
    assign branch_count      = bcnt_q;
    assign mispredict_count  = mcnt_q;
endmodule
